// File: rtl/data_mem_controller_pkg.sv
// Shared encodings for the data-memory controller and its load extender.
package data_mem_controller_pkg;

   // Access size encoding (2'b10 is illegal)
   localparam logic [1:0] BYTE      = 2'b00;
   localparam logic [1:0] HALF_WORD = 2'b01;
   localparam logic [1:0] WORD      = 2'b11;

   // Controller sequencing states
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      RESP   = 2'b10
   } state_t;

   // Owner of the current access
   localparam logic GNT_CPU = 1'b0;
   localparam logic GNT_DBG = 1'b1;

   // Legal size and naturally aligned address
   function automatic logic access_ok(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         BYTE:      access_ok = 1'b1;
         HALF_WORD: access_ok = ~addr_lo[0];
         WORD:      access_ok = (addr_lo == 2'b00);
         default:   access_ok = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/data_mem_controller_load_extender.sv
// Big-endian load extraction with sign/zero extension; zero on illegal access.
module load_extender
   import data_mem_controller_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        zero_ext,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] word_in,
   output logic [31:0] word_out
);

   // The RAM returns the addressed byte in the top lane, so extraction is always from the MSBs
   always_comb begin
      word_out = '0;
      if (access_ok(size, addr_lo)) begin
         case (size)
            BYTE:      word_out = {{24{~zero_ext & word_in[31]}}, word_in[31:24]};
            HALF_WORD: word_out = {{16{~zero_ext & word_in[31]}}, word_in[31:16]};
            default:   word_out = word_in;
         endcase
      end
   end

endmodule

// File: rtl/data_mem_controller.sv
// Arbitrates CPU load/store and debug word reads onto one data RAM; 3-cycle request/ack.
module data_mem_controller
   import data_mem_controller_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 8,
   parameter int STARVE_MAX = 4
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_cpu_req,
   input  logic                    i_cpu_we,
   input  logic [1:0]              i_cpu_size,
   input  logic                    i_cpu_unsigned,
   input  logic [ADDR_WIDTH-1:0]   i_cpu_addr,
   input  logic [4*DATA_WIDTH-1:0] i_cpu_wdata,
   output logic                    o_cpu_ack,
   output logic                    o_cpu_err,
   output logic [4*DATA_WIDTH-1:0] o_cpu_rdata,
   input  logic                    i_dbg_req,
   input  logic [ADDR_WIDTH-1:0]   i_dbg_addr,
   output logic                    o_dbg_ack,
   output logic [4*DATA_WIDTH-1:0] o_dbg_rdata,
   output logic                    o_ram_we,
   output logic [1:0]              o_ram_width,
   output logic [ADDR_WIDTH-1:0]   o_ram_addr,
   output logic [4*DATA_WIDTH-1:0] o_ram_wdata,
   input  logic [4*DATA_WIDTH-1:0] i_ram_rdata
);

   localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   state_t          state, next_state;
   logic            gnt;
   logic [1:0]      lat_size;
   logic            lat_zext;
   logic            lat_we;
   logic            lat_ok;
   logic [CW-1:0]   starve_cnt;
   logic            dbg_win;
   logic            cpu_ok;
   logic [31:0]     ext_word;

   // Debug wins only when CPU is idle or debug has waited STARVE_MAX CPU grants
   assign dbg_win = i_dbg_req & (~i_cpu_req | (starve_cnt == CW'(STARVE_MAX)));
   assign cpu_ok  = access_ok(i_cpu_size, i_cpu_addr[1:0]);

   load_extender u_ext (
      .size     (lat_size),
      .zero_ext (lat_zext),
      .addr_lo  (o_ram_addr[1:0]),
      .word_in  (i_ram_rdata),
      .word_out (ext_word)
   );

   // State register
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state <= IDLE;
      else         state <= next_state;
   end

   // Next-state: one access is always IDLE -> ACCESS -> RESP
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (i_cpu_req | i_dbg_req) next_state = ACCESS;
         ACCESS:  next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Grant latch, RAM port drive, response capture and starvation count
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         gnt         <= GNT_CPU;
         lat_size    <= '0;
         lat_zext    <= 1'b0;
         lat_we      <= 1'b0;
         lat_ok      <= 1'b0;
         starve_cnt  <= '0;
         o_cpu_ack   <= 1'b0;
         o_cpu_err   <= 1'b0;
         o_cpu_rdata <= '0;
         o_dbg_ack   <= 1'b0;
         o_dbg_rdata <= '0;
         o_ram_we    <= 1'b0;
         o_ram_width <= '0;
         o_ram_addr  <= '0;
         o_ram_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (dbg_win) begin
                  gnt         <= GNT_DBG;
                  lat_ok      <= 1'b1;
                  lat_we      <= 1'b0;
                  starve_cnt  <= '0;
                  o_ram_we    <= 1'b0;
                  o_ram_width <= WORD;
                  o_ram_addr  <= i_dbg_addr & ~ADDR_WIDTH'(3);
               end else if (i_cpu_req) begin
                  gnt         <= GNT_CPU;
                  lat_size    <= i_cpu_size;
                  lat_zext    <= i_cpu_unsigned;
                  lat_we      <= i_cpu_we;
                  lat_ok      <= cpu_ok;
                  starve_cnt  <= i_dbg_req ? starve_cnt + 1'b1 : '0;
                  o_ram_we    <= i_cpu_we & cpu_ok;
                  o_ram_width <= i_cpu_size;
                  o_ram_addr  <= i_cpu_addr;
                  o_ram_wdata <= i_cpu_wdata;
               end else begin
                  starve_cnt  <= '0;
               end
            end
            ACCESS: begin
               o_ram_we <= 1'b0;
               if (gnt == GNT_DBG) begin
                  o_dbg_ack   <= 1'b1;
                  o_dbg_rdata <= i_ram_rdata;
               end else begin
                  o_cpu_ack   <= 1'b1;
                  o_cpu_err   <= ~lat_ok;
                  o_cpu_rdata <= lat_we ? '0 : ext_word;
               end
            end
            default: begin
               o_cpu_ack <= 1'b0;
               o_cpu_err <= 1'b0;
               o_dbg_ack <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_controller.sv
// Directed + randomized bench for data_mem_controller with a byte-array reference model.
module tb_data_mem_controller;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b0;
   logic        i_cpu_req = 1'b0, i_cpu_we = 1'b0, i_cpu_unsigned = 1'b0;
   logic [1:0]  i_cpu_size = 2'b00;
   logic [11:0] i_cpu_addr = '0, i_dbg_addr = '0;
   logic [31:0] i_cpu_wdata = '0;
   logic        i_dbg_req = 1'b0;
   logic        o_cpu_ack, o_cpu_err, o_dbg_ack, o_ram_we;
   logic [31:0] o_cpu_rdata, o_dbg_rdata, o_ram_wdata, i_ram_rdata;
   logic [1:0]  o_ram_width;
   logic [11:0] o_ram_addr;

   int tests = 0;
   int fails = 0;

   logic [7:0] mem     [4096];
   logic [7:0] ref_mem [4096];
   logic       do_copy = 1'b0;
   int         we_cycles = 0;
   logic [1:0] last_width = 2'b00;

   data_mem_controller #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .STARVE_MAX(4)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we), .i_cpu_size(i_cpu_size),
      .i_cpu_unsigned(i_cpu_unsigned), .i_cpu_addr(i_cpu_addr), .i_cpu_wdata(i_cpu_wdata),
      .o_cpu_ack(o_cpu_ack), .o_cpu_err(o_cpu_err), .o_cpu_rdata(o_cpu_rdata),
      .i_dbg_req(i_dbg_req), .i_dbg_addr(i_dbg_addr),
      .o_dbg_ack(o_dbg_ack), .o_dbg_rdata(o_dbg_rdata),
      .o_ram_we(o_ram_we), .o_ram_width(o_ram_width), .o_ram_addr(o_ram_addr),
      .o_ram_wdata(o_ram_wdata), .i_ram_rdata(i_ram_rdata)
   );

   always #5 i_clk = ~i_clk;

   // Big-endian RAM: async read, sync write of the low bytes of wdata
   assign i_ram_rdata = {mem[o_ram_addr], mem[o_ram_addr + 12'd1],
                         mem[o_ram_addr + 12'd2], mem[o_ram_addr + 12'd3]};

   always @(posedge i_clk) begin
      if (do_copy) begin
         for (int i = 0; i < 4096; i++) mem[i] <= ref_mem[i];
      end else if (o_ram_we) begin
         we_cycles  <= we_cycles + 1;
         last_width <= o_ram_width;
         case (o_ram_width)
            2'b00: mem[o_ram_addr] <= o_ram_wdata[7:0];
            2'b01: begin
               mem[o_ram_addr]         <= o_ram_wdata[15:8];
               mem[o_ram_addr + 12'd1] <= o_ram_wdata[7:0];
            end
            2'b11: begin
               mem[o_ram_addr]         <= o_ram_wdata[31:24];
               mem[o_ram_addr + 12'd1] <= o_ram_wdata[23:16];
               mem[o_ram_addr + 12'd2] <= o_ram_wdata[15:8];
               mem[o_ram_addr + 12'd3] <= o_ram_wdata[7:0];
            end
            default: ;
         endcase
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] ref_word(input logic [11:0] a);
      return {ref_mem[a], ref_mem[a + 12'd1], ref_mem[a + 12'd2], ref_mem[a + 12'd3]};
   endfunction

   // One CPU access from an idle controller; expectations come from ref_mem
   task automatic cpu_op(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [11:0] a, input logic [31:0] wd, output logic [31:0] rd);
      int cyc, w0;
      logic legal, hit, got_err;
      logic [31:0] expv, v;
      legal = (sz == 2'b00) || (sz == 2'b01 && !a[0]) || (sz == 2'b11 && a[1:0] == 2'b00);
      expv = 0;
      if (legal && !we) begin
         if (sz == 2'b00) begin
            v = 32'(ref_mem[a]);
            if (!uns && v >= 128) v = v - 256;
            expv = v;
         end else if (sz == 2'b01) begin
            v = 32'(ref_mem[a]) * 256 + 32'(ref_mem[a + 12'd1]);
            if (!uns && v >= 32768) v = v - 65536;
            expv = v;
         end else begin
            expv = ref_word(a);
         end
      end
      w0 = we_cycles;
      i_cpu_we = we; i_cpu_size = sz; i_cpu_unsigned = uns; i_cpu_addr = a; i_cpu_wdata = wd;
      i_cpu_req = 1'b1;
      cyc = 0; hit = 1'b0;
      while (cyc < 20) begin
         @(posedge i_clk); #1; cyc++;
         if (o_cpu_ack) begin hit = 1'b1; break; end
      end
      got_err = o_cpu_err; rd = o_cpu_rdata;
      i_cpu_req = 1'b0;
      chk({tag, "/ack"}, hit, 1);
      chk({tag, "/lat"}, cyc, 2);
      chk({tag, "/err"}, got_err, !legal);
      chk({tag, "/rdata"}, rd, expv);
      @(posedge i_clk); #1;
      chk({tag, "/we_cycles"}, we_cycles - w0, (legal && we) ? 1 : 0);
      if (legal && we) begin
         chk({tag, "/width"}, last_width, sz);
         if (sz == 2'b00) ref_mem[a] = wd[7:0];
         else if (sz == 2'b01) begin ref_mem[a] = wd[15:8]; ref_mem[a + 12'd1] = wd[7:0]; end
         else begin
            ref_mem[a] = wd[31:24]; ref_mem[a + 12'd1] = wd[23:16];
            ref_mem[a + 12'd2] = wd[15:8]; ref_mem[a + 12'd3] = wd[7:0];
         end
      end
   endtask

   task automatic dbg_op(input string tag, input logic [11:0] a);
      int cyc, w0;
      logic hit;
      logic [31:0] rd;
      w0 = we_cycles;
      i_dbg_addr = a; i_dbg_req = 1'b1;
      cyc = 0; hit = 1'b0;
      while (cyc < 20) begin
         @(posedge i_clk); #1; cyc++;
         if (o_dbg_ack) begin hit = 1'b1; break; end
      end
      rd = o_dbg_rdata;
      i_dbg_req = 1'b0;
      chk({tag, "/ack"}, hit, 1);
      chk({tag, "/lat"}, cyc, 2);
      chk({tag, "/rdata"}, rd, ref_word(a & 12'hFFC));
      @(posedge i_clk); #1;
      chk({tag, "/we_cycles"}, we_cycles - w0, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      int cyc, nacks, last, tc, td, w0;
      int seen;

      for (int i = 0; i < 4096; i++) ref_mem[i] = 8'($urandom);

      // Reset and preload RAM
      #1 i_reset = 1'b1;
      #1 chk("reset_outputs_zero",
             32'(|{o_cpu_ack, o_cpu_err, o_cpu_rdata, o_dbg_ack, o_dbg_rdata,
                   o_ram_we, o_ram_width, o_ram_addr, o_ram_wdata}), 0);
      do_copy = 1'b1;
      @(posedge i_clk); #1;
      do_copy = 1'b0;
      @(negedge i_clk) i_reset = 1'b0;
      @(posedge i_clk); #1;

      // Word store/load and sub-word extraction
      cpu_op("sw_010", 1, 2'b11, 0, 12'h010, 32'hDEADBEEF, rd);
      cpu_op("lw_010", 0, 2'b11, 0, 12'h010, 0, rd);
      chk("lw_010_const", rd, 32'hDEADBEEF);
      cpu_op("lb_011", 0, 2'b00, 0, 12'h011, 0, rd);
      chk("lb_011_const", rd, 32'hFFFFFFAD);
      cpu_op("lbu_011", 0, 2'b00, 1, 12'h011, 0, rd);
      chk("lbu_011_const", rd, 32'h000000AD);
      cpu_op("lh_012", 0, 2'b01, 0, 12'h012, 0, rd);
      chk("lh_012_const", rd, 32'hFFFFBEEF);
      cpu_op("lhu_012", 0, 2'b01, 1, 12'h012, 0, rd);
      chk("lhu_012_const", rd, 32'h0000BEEF);

      // Misaligned / illegal accesses
      cpu_op("sh_013_mis", 1, 2'b01, 0, 12'h013, 32'h00001234, rd);
      cpu_op("lw_012_mis", 0, 2'b11, 0, 12'h012, 0, rd);
      cpu_op("ld_size10", 0, 2'b10, 0, 12'h010, 0, rd);
      cpu_op("st_size10", 1, 2'b10, 0, 12'h010, 32'h55555555, rd);
      cpu_op("lw_010_after", 0, 2'b11, 0, 12'h010, 0, rd);
      chk("lw_010_unchanged", rd, 32'hDEADBEEF);
      dbg_op("dbg_013", 12'h013);

      // Both requesters held: four CPU grants then one debug grant, repeating
      i_cpu_we = 0; i_cpu_size = 2'b11; i_cpu_unsigned = 0; i_cpu_addr = 12'h010;
      i_dbg_addr = 12'h013; i_cpu_req = 1; i_dbg_req = 1;
      nacks = 0; cyc = 0; last = 0;
      while (nacks < 10 && cyc < 100) begin
         @(posedge i_clk); #1; cyc++;
         if (o_cpu_ack || o_dbg_ack) begin
            chk($sformatf("arb%0d_owner_dbg", nacks), o_dbg_ack, (nacks % 5) == 4);
            chk($sformatf("arb%0d_single_ack", nacks), o_dbg_ack & o_cpu_ack, 0);
            chk($sformatf("arb%0d_gap", nacks), cyc - last, (nacks == 0) ? 2 : 3);
            chk($sformatf("arb%0d_data", nacks), o_dbg_ack ? o_dbg_rdata : o_cpu_rdata,
                ref_word(12'h010));
            last = cyc;
            nacks++;
         end
      end
      i_cpu_req = 0; i_dbg_req = 0;
      chk("arb_ack_count", nacks, 10);
      @(posedge i_clk); #1;

      // Simultaneous single requests: CPU first, debug three cycles later
      i_cpu_addr = 12'h010; i_dbg_addr = 12'h020;
      i_cpu_req = 1; i_dbg_req = 1;
      tc = 0; td = 0; cyc = 0;
      while ((tc == 0 || td == 0) && cyc < 30) begin
         @(posedge i_clk); #1; cyc++;
         if (o_cpu_ack) begin tc = cyc; i_cpu_req = 0; end
         if (o_dbg_ack) begin td = cyc; i_dbg_req = 0; end
      end
      i_cpu_req = 0; i_dbg_req = 0;
      chk("simul_cpu_ack_cycle", tc, 2);
      chk("simul_dbg_ack_cycle", td, 5);
      @(posedge i_clk); #1;

      // Reset during a store's ACCESS cycle
      cpu_op("sw_020_pre", 1, 2'b11, 0, 12'h020, 32'h11223344, rd);
      w0 = we_cycles;
      i_cpu_we = 1; i_cpu_size = 2'b11; i_cpu_addr = 12'h020; i_cpu_wdata = 32'hCAFEF00D;
      i_cpu_req = 1;
      @(posedge i_clk); #1;
      chk("rst_store_we_in_access", o_ram_we, 1);
      i_reset = 1'b1;
      #1;
      chk("rst_we_drops", o_ram_we, 0);
      chk("rst_all_outputs_zero",
          32'(|{o_cpu_ack, o_cpu_err, o_cpu_rdata, o_dbg_ack, o_dbg_rdata,
                o_ram_we, o_ram_width, o_ram_addr, o_ram_wdata}), 0);
      i_cpu_req = 0;
      @(posedge i_clk); #1;
      @(negedge i_clk) i_reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge i_clk); #1;
         if (o_cpu_ack || o_dbg_ack) seen++;
      end
      chk("rst_no_ack", seen, 0);
      chk("rst_no_write", we_cycles - w0, 0);
      cpu_op("lw_020_post", 0, 2'b11, 0, 12'h020, 0, rd);
      chk("lw_020_pre_value", rd, 32'h11223344);

      // Randomized CPU traffic with occasional debug reads
      for (int n = 0; n < 40; n++) begin
         logic [11:0] ra;
         logic [1:0]  rs;
         ra = 12'($urandom);
         rs = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) != 0) ra = ra & ((rs == 2'b11) ? 12'hFFC : (rs == 2'b01) ? 12'hFFE : 12'hFFF);
         cpu_op($sformatf("rnd%0d", n), 1'($urandom), rs, 1'($urandom), ra, $urandom, rd);
         if (n % 5 == 4) dbg_op($sformatf("rnd_dbg%0d", n), ra);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
